// File: rtl/id_stage_pipe.sv
// Registered ID/EX stage with a per-register pending-write scoreboard that stalls RAW/WAW hazards.
// Optional macro ID_WB_BYPASS_EN: a writeback clears the pending bit for hazard checks in the same cycle.
module id_stage_pipe #(
    parameter int BUS_WIDTH   = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int REGFILE_LEN = 6,
    parameter int CTRL_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BUS_WIDTH-1:0]   in_pc,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic [REGFILE_LEN-1:0] in_rs1,
    input  logic [REGFILE_LEN-1:0] in_rs2,
    input  logic [REGFILE_LEN-1:0] in_rd,
    input  logic                   in_use_rs1,
    input  logic                   in_use_rs2,
    input  logic                   in_reg_write,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BUS_WIDTH-1:0]   out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [CTRL_WIDTH-1:0]  out_ctrl,
    output logic [REGFILE_LEN-1:0] out_rs1,
    output logic [REGFILE_LEN-1:0] out_rs2,
    output logic [REGFILE_LEN-1:0] out_rd,
    output logic                   out_reg_write,

    input  logic                   wb_valid,
    input  logic [REGFILE_LEN-1:0] wb_rd,
    input  logic                   flush,
    output logic                   busy,
    output logic [31:0]            stall_count
);

    localparam int NUM_REGS = 1 << REGFILE_LEN;

    logic                   out_valid_q,     out_valid_d;
    logic [BUS_WIDTH-1:0]   out_pc_q,        out_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q,     out_instr_d;
    logic [CTRL_WIDTH-1:0]  out_ctrl_q,      out_ctrl_d;
    logic [REGFILE_LEN-1:0] out_rs1_q,       out_rs1_d;
    logic [REGFILE_LEN-1:0] out_rs2_q,       out_rs2_d;
    logic [REGFILE_LEN-1:0] out_rd_q,        out_rd_d;
    logic                   out_reg_write_q, out_reg_write_d;
    logic [31:0]            stall_count_q,   stall_count_d;
    logic [NUM_REGS-1:0]    pending_q,       pending_d;

    logic [NUM_REGS-1:0]    hit_vec;
    logic                   hazard;
    logic                   accept;
    logic                   out_fire;
    logic                   stall;

    // Per-register hit and next pending state; x0 is hardwired clear and never hazards.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign hit_vec[gi]   = 1'b0;
                assign pending_d[gi] = 1'b0;
            end else begin : g_reg
                logic wb_hit;
                logic held_hit;
                logic fire_set;
                logic pend_eff;

                assign wb_hit   = wb_valid && (wb_rd == REGFILE_LEN'(gi));
                assign held_hit = out_valid_q && out_reg_write_q && (out_rd_q == REGFILE_LEN'(gi));
                assign fire_set = out_fire && out_reg_write_q && (out_rd_q == REGFILE_LEN'(gi));
`ifdef ID_WB_BYPASS_EN
                assign pend_eff = pending_q[gi] && !wb_hit;
`else
                assign pend_eff = pending_q[gi];
`endif
                assign hit_vec[gi]   = pend_eff || held_hit;
                // A set from the issuing instruction beats a same-cycle writeback clear.
                assign pending_d[gi] = fire_set || (pending_q[gi] && !wb_hit);
            end
        end
    endgenerate

    always_comb begin
        hazard   = (in_use_rs1   && hit_vec[in_rs1])
                || (in_use_rs2   && hit_vec[in_rs2])
                || (in_reg_write && hit_vec[in_rd]);
        in_ready = !flush && !hazard && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        out_fire = out_valid_q && out_ready && !flush;
        stall    = in_valid && !in_ready && !flush;
    end

    always_comb begin
        out_valid_d     = out_valid_q;
        out_pc_d        = out_pc_q;
        out_instr_d     = out_instr_q;
        out_ctrl_d      = out_ctrl_q;
        out_rs1_d       = out_rs1_q;
        out_rs2_d       = out_rs2_q;
        out_rd_d        = out_rd_q;
        out_reg_write_d = out_reg_write_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d     = 1'b1;
            out_pc_d        = in_pc;
            out_instr_d     = in_instr;
            out_ctrl_d      = in_ctrl;
            out_rs1_d       = in_rs1;
            out_rs2_d       = in_rs2;
            out_rd_d        = in_rd;
            out_reg_write_d = in_reg_write;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_pc_q        <= '0;
            out_instr_q     <= '0;
            out_ctrl_q      <= '0;
            out_rs1_q       <= '0;
            out_rs2_q       <= '0;
            out_rd_q        <= '0;
            out_reg_write_q <= 1'b0;
            stall_count_q   <= '0;
            pending_q       <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_pc_q        <= out_pc_d;
            out_instr_q     <= out_instr_d;
            out_ctrl_q      <= out_ctrl_d;
            out_rs1_q       <= out_rs1_d;
            out_rs2_q       <= out_rs2_d;
            out_rd_q        <= out_rd_d;
            out_reg_write_q <= out_reg_write_d;
            stall_count_q   <= stall_count_d;
            pending_q       <= pending_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign out_instr     = out_instr_q;
    assign out_ctrl      = out_ctrl_q;
    assign out_rs1       = out_rs1_q;
    assign out_rs2       = out_rs2_q;
    assign out_rd        = out_rd_q;
    assign out_reg_write = out_reg_write_q;
    assign busy          = |pending_q;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe; expectations follow ID_WB_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_id_stage_pipe;

    localparam int BW = 64;
    localparam int IW = 32;
    localparam int RL = 6;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [BW-1:0] in_pc;
    logic [IW-1:0] in_instr;
    logic [CW-1:0] in_ctrl;
    logic [RL-1:0] in_rs1, in_rs2, in_rd;
    logic          in_use_rs1, in_use_rs2, in_reg_write;
    logic          out_valid, out_ready;
    logic [BW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic [CW-1:0] out_ctrl;
    logic [RL-1:0] out_rs1, out_rs2, out_rd;
    logic          out_reg_write;
    logic          wb_valid;
    logic [RL-1:0] wb_rd;
    logic          flush;
    logic          busy;
    logic [31:0]   stall_count;

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.BUS_WIDTH(BW), .INSTR_WIDTH(IW), .REGFILE_LEN(RL), .CTRL_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .in_ctrl(in_ctrl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_reg_write(in_reg_write),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_ctrl(out_ctrl), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy(busy), .stall_count(stall_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [BW-1:0] pc, input int rs1, input int rs2, input int rd,
                         input logic u1, input logic u2, input logic rw);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_instr     = pc[IW-1:0] ^ 32'hA5A5_0000;
        in_ctrl      = pc[CW-1:0];
        in_rs1       = RL'(rs1);
        in_rs2       = RL'(rs2);
        in_rd        = RL'(rd);
        in_use_rs1   = u1;
        in_use_rs2   = u2;
        in_reg_write = rw;
        $display("txn pc=0x%0h rs1=%0d rs2=%0d rd=%0d use=%b%b wr=%b", pc, rs1, rs2, rd, u1, u2, rw);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_ctrl = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_use_rs1 = 1'b0; in_use_rs2 = 1'b0;
        in_reg_write = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;

        // Reset state
        step(); step();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_stall_count", 64'(stall_count), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_pc", out_pc, 64'd0);
        rst = 1'b0;

        // Four independent ops at full throughput
        for (int i = 0; i < 4; i++) begin
            drive(64'h1000 + 64'(i * 4), i + 1, i + 2, i + 3, 1'b1, 1'b1, 1'b0);
            #1 check_eq("stream_in_ready", 64'(in_ready), 64'd1);
            step();
            check_eq("stream_out_valid", 64'(out_valid), 64'd1);
            check_eq("stream_out_pc", out_pc, 64'h1000 + 64'(i * 4));
            check_eq("stream_out_instr", 64'(out_instr), 64'((32'h1000 + 32'(i * 4)) ^ 32'hA5A5_0000));
            check_eq("stream_out_rd", 64'(out_rd), 64'(i + 3));
        end
        in_valid = 1'b0;
        step();
        check_eq("stream_drain", 64'(out_valid), 64'd0);
        check_eq("stream_stalls", 64'(stall_count), 64'd0);

        // RAW on r5
        drive(64'h2000, 0, 0, 5, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("raw_prod_valid", 64'(out_valid), 64'd1);
        check_eq("raw_prod_rd", 64'(out_rd), 64'd5);
        drive(64'h2004, 5, 0, 6, 1'b1, 1'b0, 1'b0);
        #1 check_eq("raw_fire_cycle_ready", 64'(in_ready), 64'd0);
        step(); exp_stall++;
        check_eq("raw_busy", 64'(busy), 64'd1);
        check_eq("raw_pending_ready", 64'(in_ready), 64'd0);
        step(); exp_stall++;
        wb_valid = 1'b1; wb_rd = 6'd5;
        #1;
`ifdef ID_WB_BYPASS_EN
        check_eq("raw_wb_cycle_ready", 64'(in_ready), 64'd1);
        step();
        wb_valid = 1'b0;
`else
        check_eq("raw_wb_cycle_ready", 64'(in_ready), 64'd0);
        step(); exp_stall++;
        wb_valid = 1'b0;
        #1 check_eq("raw_after_wb_ready", 64'(in_ready), 64'd1);
        check_eq("raw_after_wb_busy", 64'(busy), 64'd0);
        step();
`endif
        check_eq("raw_cons_valid", 64'(out_valid), 64'd1);
        check_eq("raw_cons_pc", out_pc, 64'h2004);
        in_valid = 1'b0;
        step();
        check_eq("raw_done_busy", 64'(busy), 64'd0);
        check_eq("raw_stall_count", 64'(stall_count), 64'(exp_stall));

        // x0 never pending; wb to x0 is harmless
        drive(64'h3000, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        step();
        drive(64'h3004, 0, 0, 0, 1'b1, 1'b1, 1'b1);
        wb_valid = 1'b1; wb_rd = 6'd0;
        #1 check_eq("x0_in_ready", 64'(in_ready), 64'd1);
        step();
        wb_valid = 1'b0;
        check_eq("x0_cons_pc", out_pc, 64'h3004);
        in_valid = 1'b0;
        step();
        check_eq("x0_busy", 64'(busy), 64'd0);
        check_eq("x0_stalls", 64'(stall_count), 64'(exp_stall));

        // f0 (address 32) is an ordinary register
        drive(64'h4000, 0, 0, 32, 1'b0, 1'b0, 1'b1);
        step();
        drive(64'h4004, 0, 32, 1, 1'b0, 1'b1, 1'b0);
        #1 check_eq("f0_fire_ready", 64'(in_ready), 64'd0);
        step(); exp_stall++;
        check_eq("f0_busy", 64'(busy), 64'd1);
        check_eq("f0_pending_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 6'd32;
        step();
        wb_valid = 1'b0;
        check_eq("f0_cleared_busy", 64'(busy), 64'd0);

        // Backpressure hold, then flush
        drive(64'h5000, 0, 0, 20, 1'b0, 1'b0, 1'b1);
        step();
        drive(64'h5004, 0, 0, 9, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("bp_load_pc", out_pc, 64'h5004);
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_pc", out_pc, 64'h5004);
            check_eq("bp_rd", 64'(out_rd), 64'd9);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        end
        check_eq("bp_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        #1 check_eq("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        check_eq("flush_busy", 64'(busy), 64'd1);
        drive(64'h5008, 9, 0, 0, 1'b1, 1'b0, 1'b0);
        #1 check_eq("flush_r9_free", 64'(in_ready), 64'd1);
        drive(64'h500c, 20, 0, 0, 1'b1, 1'b0, 1'b0);
        #1 check_eq("flush_r20_held", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 6'd20;
        step();
        wb_valid = 1'b0;
        check_eq("flush_wb_busy", 64'(busy), 64'd0);

        // Same-cycle issue of r7 and writeback of r7: set wins
        drive(64'h6000, 0, 0, 7, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 6'd7;
        step();
        wb_valid = 1'b0;
        check_eq("setclr_busy", 64'(busy), 64'd1);
        drive(64'h6004, 7, 0, 0, 1'b1, 1'b0, 1'b0);
        #1 check_eq("setclr_ready", 64'(in_ready), 64'd0);
        step(); exp_stall++;
        check_eq("setclr_still_stalled", 64'(in_ready), 64'd0);
        wb_valid = 1'b1; wb_rd = 6'd7;
        #1;
`ifdef ID_WB_BYPASS_EN
        check_eq("setclr_wb_ready", 64'(in_ready), 64'd1);
        step();
        wb_valid = 1'b0;
`else
        check_eq("setclr_wb_ready", 64'(in_ready), 64'd0);
        step(); exp_stall++;
        wb_valid = 1'b0;
        #1 check_eq("setclr_after_wb_ready", 64'(in_ready), 64'd1);
        step();
`endif
        check_eq("setclr_cons_pc", out_pc, 64'h6004);
        in_valid = 1'b0;
        step();
        check_eq("setclr_out_valid", 64'(out_valid), 64'd0);
        check_eq("setclr_done_busy", 64'(busy), 64'd0);
        check_eq("setclr_stall_count", 64'(stall_count), 64'(exp_stall));

        // Reset in the middle of a stall
        drive(64'h7000, 0, 0, 8, 1'b0, 1'b0, 1'b1);
        step();
        drive(64'h7004, 8, 0, 0, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("midrst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_stall_count", 64'(stall_count), 64'd0);
        check_eq("midrst_out_pc", out_pc, 64'd0);
        #1 check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
